// File: rtl/tdm_ingress_mux_pkg.sv
// tdm_ingress_mux_pkg: shared widths and the per-byte FIFO entry for the TDM ingress stage
package tdm_ingress_mux_pkg;
    localparam int TDM_DATA_W     = 8;
    localparam int TDM_SLOT_W     = 8;
    localparam int TDM_NUM_PORTS  = 14;
    localparam int TDM_FIFO_DEPTH = 16;
    typedef struct packed {
        logic                  sop;
        logic [TDM_DATA_W-1:0] data;
    } tdm_entry_t;
endpackage

// File: rtl/tdm_ingress_mux_if.sv
// tdm_ingress_mux_if: per-port ingress handshake plus the interleaved TDM byte bus
interface tdm_ingress_mux_if
    import tdm_ingress_mux_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_W,
    parameter int NUM_PORTS  = TDM_NUM_PORTS,
    parameter int SLOT_W     = TDM_SLOT_W
);
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_sop;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_ready;
    logic                            tdm_valid;
    logic                            tdm_new_pkt;
    logic [DATA_WIDTH-1:0]           tdm_data;
    logic [SLOT_W-1:0]               tdm_slot;
    modport master (
        output in_valid, in_sop, in_data,
        input  in_ready, tdm_valid, tdm_new_pkt, tdm_data, tdm_slot
    );
    modport slave (
        input  in_valid, in_sop, in_data,
        output in_ready, tdm_valid, tdm_new_pkt, tdm_data, tdm_slot
    );
endinterface

// File: rtl/tdm_byte_fifo.sv
// tdm_byte_fifo: single-clock FIFO of tdm_entry_t; flop storage, head entry always visible on rd_entry
module tdm_byte_fifo
    import tdm_ingress_mux_pkg::*;
#(
    parameter int DEPTH = TDM_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  tdm_entry_t wr_entry,
    output tdm_entry_t rd_entry,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    tdm_entry_t  mem [DEPTH];
    // extra pointer bit separates full from empty when the indices coincide
    assign full     = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign empty    = wr_ptr == rd_ptr;
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
endmodule

// File: rtl/tdm_ingress_mux.sv
// tdm_ingress_mux: buffers per-port byte streams and interleaves them onto the core's TDM slots.
// TDM_INGRESS_STATS_EN adds per-port saturating counts of bytes sent to the bus (stat_bytes).
module tdm_ingress_mux
    import tdm_ingress_mux_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_W,
    parameter int NUM_PORTS  = TDM_NUM_PORTS,
    parameter int SLOT_W     = TDM_SLOT_W,
    parameter int FIFO_DEPTH = TDM_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef TDM_INGRESS_STATS_EN
    output logic [NUM_PORTS*32-1:0] stat_bytes,
`endif
    tdm_ingress_mux_if.slave        bus
);
    logic [SLOT_W-1:0]    slot_q, n;
    logic [NUM_PORTS-1:0] full, empty, pop;
    tdm_entry_t           rd [NUM_PORTS];
    tdm_entry_t           sel;
    // pop one slot ahead so the registered output lines up with tdm_slot
    assign n            = slot_q + SLOT_W'(1);
    assign bus.in_ready = ~full;
    assign bus.tdm_slot = slot_q;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tdm_entry_t wr;
        assign wr     = {bus.in_sop[p], bus.in_data[p*DATA_WIDTH +: DATA_WIDTH]};
        assign pop[p] = (n == SLOT_W'(p)) && !empty[p];
        tdm_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (bus.in_valid[p]),
            .pop      (pop[p]),
            .wr_entry (wr),
            .rd_entry (rd[p]),
            .full     (full[p]),
            .empty    (empty[p])
        );
`ifdef TDM_INGRESS_STATS_EN
        logic [31:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt <= '0;
            else if (pop[p] && cnt != '1) cnt <= cnt + 32'd1;
        end
        assign stat_bytes[p*32 +: 32] = cnt;
`endif
    end
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) sel = pop[i] ? rd[i] : sel;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q          <= '0;
            bus.tdm_valid   <= 1'b0;
            bus.tdm_new_pkt <= 1'b0;
            bus.tdm_data    <= '0;
        end else begin
            slot_q          <= n;
            bus.tdm_valid   <= |pop;
            bus.tdm_new_pkt <= sel.sop;
            bus.tdm_data    <= sel.data;
        end
    end
endmodule
